// File: rtl/hbridge_pwm_ctrl.sv
// rtl/hbridge_pwm_ctrl.sv - APB3 H-bridge PWM controller with per-channel reversal dead-time
// Optional watchdog built in when HBRIDGE_WDOG_EN is defined.
module hbridge_pwm_ctrl #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          NUM_CH      = 2,
  parameter int          PWM_W       = 12,
  parameter int          DEAD_CYCLES = 64,
  parameter int          WDOG_W      = 24
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [2*NUM_CH-1:0]   HBRIDGE_CMD,
  output logic [NUM_CH-1:0]     HBRIDGE_EN
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2} state_t;

  logic [15:0]      off;
  logic             wr, wr_period, wrap, trip_q;
  logic [PWM_W-1:0] period_q, cnt_q;
  logic [1:0]       ctrl_cmd_q [NUM_CH];
  logic [NUM_CH-1:0] ctrl_en_q, wr_ctrl, wr_duty, pwm, en_q;
  logic [PWM_W-1:0] duty_sh_q [NUM_CH];
  logic [PWM_W-1:0] duty_sh_nxt [NUM_CH];
  logic [PWM_W-1:0] duty_act_q [NUM_CH];
  state_t           state_q [NUM_CH];
  logic [DW-1:0]    dead_q [NUM_CH];
  logic [1:0]       applied_q [NUM_CH];
  logic [1:0]       cmd_q [NUM_CH];
  logic             unused_bits;

  function automatic logic is_dir(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  assign off         = PADDR[15:0] - BASE_ADDR;
  assign wr          = PSEL & PENABLE & PWRITE;
  assign wr_period   = wr && (off == 16'h0000);
  assign wrap        = (period_q != '0) && (cnt_q >= period_q - PWM_W'(1));
  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign HBRIDGE_EN  = en_q;
  assign unused_bits = ^{PADDR[31:16], PWDATA};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ctrl[i]     = wr && (off == 16'(16 + 8 * i));
      wr_duty[i]     = wr && (off == 16'(20 + 8 * i));
      duty_sh_nxt[i] = wr_duty[i] ? PWDATA[PWM_W-1:0] : duty_sh_q[i];
      pwm[i]         = (period_q != '0) ? (cnt_q < duty_act_q[i]) : (duty_act_q[i] != '0);
      HBRIDGE_CMD[2*i +: 2] = cmd_q[i];
    end
  end

  // Shared PWM timebase; a PERIOD write restarts it from zero.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_period) period_q <= PWDATA[PWM_W-1:0];
      if (wr_period || wrap || period_q == '0) cnt_q <= '0;
      else cnt_q <= cnt_q + PWM_W'(1);
    end
  end

`ifdef HBRIDGE_WDOG_EN
  logic [WDOG_W-1:0] wdog_load_q, wdog_load_nxt, wdog_cnt_q;

  assign wdog_load_nxt = (wr && off == 16'h0008) ? PWDATA[WDOG_W-1:0] : wdog_load_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wdog_load_q <= '0;
      wdog_cnt_q  <= '0;
      trip_q      <= 1'b0;
    end else begin
      wdog_load_q <= wdog_load_nxt;
      if (wr) wdog_cnt_q <= wdog_load_nxt;
      else if (wdog_cnt_q != '0) wdog_cnt_q <= wdog_cnt_q - WDOG_W'(1);
      if (wr && off == 16'h0004 && PWDATA[8]) trip_q <= 1'b0;
      else if (!wr && wdog_cnt_q == WDOG_W'(1) && wdog_load_q != '0) trip_q <= 1'b1;
    end
  end
`else
  assign trip_q = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (PRESET) begin
        ctrl_cmd_q[i] <= '0;
        ctrl_en_q[i]  <= 1'b0;
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
        state_q[i]    <= ST_IDLE;
        dead_q[i]     <= '0;
        applied_q[i]  <= '0;
        cmd_q[i]      <= '0;
        en_q[i]       <= 1'b0;
      end else begin
        if (wr_ctrl[i]) ctrl_cmd_q[i] <= PWDATA[1:0];
        if (trip_q) ctrl_en_q[i] <= 1'b0;
        else if (wr_ctrl[i]) ctrl_en_q[i] <= PWDATA[2];
        duty_sh_q[i] <= duty_sh_nxt[i];
        if (wr_period || wrap || period_q == '0 || state_q[i] == ST_IDLE)
          duty_act_q[i] <= duty_sh_nxt[i];

        if (trip_q) begin
          state_q[i]   <= ST_IDLE;
          applied_q[i] <= ctrl_cmd_q[i];
          cmd_q[i]     <= 2'b11;
          en_q[i]      <= 1'b0;
        end else begin
          case (state_q[i])
            ST_RUN: begin
              if (!ctrl_en_q[i]) begin
                state_q[i]   <= ST_IDLE;
                applied_q[i] <= ctrl_cmd_q[i];
                cmd_q[i]     <= ctrl_cmd_q[i];
                en_q[i]      <= 1'b0;
              end else if (ctrl_cmd_q[i] != applied_q[i] &&
                           (is_dir(ctrl_cmd_q[i]) || is_dir(applied_q[i]))) begin
                // Outputs coast from this edge; DEAD_CYCLES-1 down to 0 spans DEAD_CYCLES cycles.
                state_q[i] <= ST_DEAD;
                dead_q[i]  <= DW'(DEAD_CYCLES - 1);
                cmd_q[i]   <= 2'b00;
                en_q[i]    <= 1'b0;
              end else begin
                applied_q[i] <= ctrl_cmd_q[i];
                cmd_q[i]     <= ctrl_cmd_q[i];
                en_q[i]      <= pwm[i];
              end
            end
            ST_DEAD: begin
              if (dead_q[i] != '0) begin
                dead_q[i] <= dead_q[i] - DW'(1);
              end else begin
                applied_q[i] <= ctrl_cmd_q[i];
                cmd_q[i]     <= ctrl_cmd_q[i];
                en_q[i]      <= ctrl_en_q[i] & pwm[i];
                state_q[i]   <= ctrl_en_q[i] ? ST_RUN : ST_IDLE;
              end
            end
            default: begin
              applied_q[i] <= ctrl_cmd_q[i];
              cmd_q[i]     <= ctrl_cmd_q[i];
              en_q[i]      <= ctrl_en_q[i] & pwm[i];
              state_q[i]   <= ctrl_en_q[i] ? ST_RUN : ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (off)
        16'h0000: PRDATA[PWM_W-1:0] = period_q;
        16'h0004: begin
          for (int i = 0; i < NUM_CH; i++) PRDATA[i] = (state_q[i] == ST_DEAD);
          PRDATA[8] = trip_q;
        end
`ifdef HBRIDGE_WDOG_EN
        16'h0008: PRDATA[WDOG_W-1:0] = wdog_load_q;
`endif
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (off == 16'(16 + 8 * i)) PRDATA[2:0] = {ctrl_en_q[i], ctrl_cmd_q[i]};
            if (off == 16'(20 + 8 * i)) PRDATA[PWM_W-1:0] = duty_sh_q[i];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hbridge_pwm_ctrl.sv
// tb/tb_hbridge_pwm_ctrl.sv - scoreboard bench for hbridge_pwm_ctrl
`timescale 1ns/1ps
module tb_hbridge_pwm_ctrl;
  localparam int NC = 2;

  logic PCLK = 1'b0, PRESET = 1'b1, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0, PRDATA;
  logic PREADY, PSLVERR;
  logic [2*NC-1:0] HBRIDGE_CMD;
  logic [NC-1:0] HBRIDGE_EN;

  int checks = 0, failures = 0;

  typedef struct { string name; logic [31:0] exp; } rd_exp_t;
  typedef struct { string name; logic [5:0] mask; logic [5:0] exp; int len; int cnt; } pin_exp_t;

  rd_exp_t  rd_q[$];
  pin_exp_t pin_q[$];
  rd_exp_t  rd_e;
  pin_exp_t win;
  logic [5:0] pins;
  logic pin_strobe = 1'b0;
  int win_left = 0, win_hits = 0;

  always #5 PCLK = ~PCLK;

  hbridge_pwm_ctrl #(.BASE_ADDR(16'h0000), .NUM_CH(NC), .PWM_W(12), .DEAD_CYCLES(64), .WDOG_W(24)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HBRIDGE_CMD(HBRIDGE_CMD), .HBRIDGE_EN(HBRIDGE_EN)
  );

  // Read monitor: every completed APB read pops one expectation.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && !PWRITE && PREADY) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got %h required none", PRDATA);
      end else begin
        rd_e = rd_q.pop_front();
        if (PRDATA !== rd_e.exp || PSLVERR !== 1'b0) begin
          failures++;
          $display("FAIL %s: got %h slverr %b required %h slverr 0", rd_e.name, PRDATA, PSLVERR, rd_e.exp);
        end
      end
    end
  end

  // Pin monitor: instant compares or counted windows of matching cycles.
  always @(negedge PCLK) begin
    pins = {HBRIDGE_CMD, HBRIDGE_EN};
    if (pin_strobe) begin
      if (pin_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pin_unexpected: got %b required none", pins);
      end else begin
        win = pin_q.pop_front();
        if (win.len == 0) begin
          checks++;
          if ((pins & win.mask) !== (win.exp & win.mask)) begin
            failures++;
            $display("FAIL %s: pins %b required %b under mask %b", win.name, pins, win.exp, win.mask);
          end
        end else begin
          win_left = win.len;
          win_hits = 0;
        end
      end
    end
    if (win_left > 0) begin
      if ((pins & win.mask) === (win.exp & win.mask)) win_hits++;
      win_left--;
      if (win_left == 0) begin
        checks++;
        if (win_hits != win.cnt) begin
          failures++;
          $display("FAIL %s: matching cycles %0d required %0d", win.name, win_hits, win.cnt);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    rd_q.push_back(e);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pins_check(input string name, input logic [5:0] mask, input logic [5:0] exp,
                            input int len, input int cnt);
    pin_exp_t e;
    e.name = name; e.mask = mask; e.exp = exp; e.len = len; e.cnt = cnt;
    pin_q.push_back(e);
    pin_strobe = 1'b1;
    @(posedge PCLK); #1;
    pin_strobe = 1'b0;
    if (len > 0) begin
      repeat (len) @(posedge PCLK);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t required finish", $time);
    $fatal(1);
  end

  initial begin
    // Pin layout {CMD[3:2], CMD[1:0], EN[1], EN[0]}
    idle(2);
    pins_check("reset_pins", 6'b111111, 6'b000000, 0, 0);
    PRESET = 1'b0;
    apb_read(32'h00, 32'h0, "reset_period");
    apb_read(32'h04, 32'h0, "reset_status");
    apb_read(32'h10, 32'h0, "reset_ctrl0");

    apb_write(32'h00, 32'd10);
    apb_write(32'h14, 32'd3);
    apb_write(32'h10, 32'h5);
    idle(3);
    pins_check("fwd_cmd", 6'b111100, 6'b000100, 0, 0);
    pins_check("pwm_3of10", 6'b000001, 6'b000001, 20, 6);
    apb_read(32'h00, 32'd10, "rb_period");
    apb_read(32'h10, 32'h5, "rb_ctrl0");
    apb_read(32'h14, 32'd3, "rb_duty0");
    apb_read(32'h40, 32'h0, "unmapped_rd");
    apb_read(32'h0C, 32'h0, "gap_rd");

    apb_write(32'h10, 32'h6);
    fork
      pins_check("dead_coast_64", 6'b001100, 6'b000000, 100, 64);
      begin
        idle(20);
        apb_read(32'h04, 32'h1, "status_dead");
      end
    join
    pins_check("rev_cmd", 6'b111100, 6'b001000, 0, 0);
    apb_read(32'h04, 32'h0, "status_after_dead");
    pins_check("pwm_resume", 6'b000001, 6'b000001, 20, 6);

    apb_write(32'h00, 32'd10);
    apb_write(32'h14, 32'd7);
    pins_check("duty_shadow_hold", 6'b000001, 6'b000001, 10, 3);
    apb_write(32'h14, 32'd10);
    idle(12);
    pins_check("duty_full", 6'b000001, 6'b000001, 20, 20);

    apb_write(32'h00, 32'd0);
    apb_write(32'h1C, 32'd1);
    apb_write(32'h18, 32'h7);
    idle(2);
    pins_check("p0_brake", 6'b111111, 6'b111011, 0, 0);
    pins_check("p0_en_steady", 6'b000010, 6'b000010, 20, 20);
    apb_write(32'h18, 32'h4);
    pins_check("coast_not_yet", 6'b110010, 6'b110010, 0, 0);
    pins_check("coast_applied", 6'b110010, 6'b000010, 0, 0);
    apb_read(32'h04, 32'h0, "coast_no_dead");

`ifdef HBRIDGE_WDOG_EN
    apb_write(32'h08, 32'd100);
    apb_read(32'h08, 32'd100, "rb_wdog_load");
    idle(110);
    pins_check("wdog_brake", 6'b111111, 6'b111100, 0, 0);
    apb_read(32'h04, 32'h100, "wdog_tripped");
    apb_read(32'h10, 32'h2, "wdog_en_cleared");
    apb_write(32'h04, 32'h100);
    apb_read(32'h04, 32'h0, "wdog_cleared");
    apb_write(32'h08, 32'd0);
    idle(2);
    pins_check("wdog_released", 6'b111111, 6'b001000, 0, 0);
`else
    apb_write(32'h08, 32'd100);
    apb_read(32'h08, 32'h0, "wdog_load_absent");
    idle(110);
    apb_read(32'h04, 32'h0, "no_wdog_trip");
`endif

    apb_write(32'h10, 32'h6);
    apb_write(32'h00, 32'd10);
    apb_write(32'h14, 32'd3);
    idle(12);
    pins_check("pwm_before_reset", 6'b000001, 6'b000001, 20, 6);
    PRESET = 1'b1;
    idle(1);
    pins_check("reset_mid_pwm", 6'b111111, 6'b000000, 0, 0);
    PRESET = 1'b0;
    pins_check("no_replay", 6'b111111, 6'b000000, 50, 50);
    apb_read(32'h00, 32'h0, "post_rst_period");
    apb_read(32'h04, 32'h0, "post_rst_status");
    apb_read(32'h08, 32'h0, "post_rst_wdog");
    apb_read(32'h10, 32'h0, "post_rst_ctrl0");
    apb_read(32'h14, 32'h0, "post_rst_duty0");
    apb_read(32'h18, 32'h0, "post_rst_ctrl1");
    apb_read(32'h1C, 32'h0, "post_rst_duty1");

    idle(2);
    checks++;
    if (rd_q.size() != 0 || pin_q.size() != 0 || win_left != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending rd %0d pin %0d window %0d required 0", rd_q.size(), pin_q.size(), win_left);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
